// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/subtract engine.
package serial_add_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_1bit.sv
// Single-bit full-adder cell used as the datapath of the serial engine.
module adder_1bit (
   input  logic a,
   input  logic b,
   input  logic carry_in,
   output logic sum,
   output logic carry_out
);

   assign sum       = a ^ b ^ carry_in;
   assign carry_out = (a & b) | (a & carry_in) | (b & carry_in);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract engine: one full-adder cell, LSB first, registered carry loop.
module serial_add_ctrl
   import serial_add_pkg::*;
#(
   parameter int NUM_BITS = 8
) (
   input  logic                clk,
   input  logic                n_rst,
   input  logic                start,
   input  logic                op_sub,
   input  logic [NUM_BITS-1:0] a,
   input  logic [NUM_BITS-1:0] b,
   output logic                busy,
   output logic                done,
   output logic [NUM_BITS-1:0] sum,
   output logic                carry_out,
   output logic                overflow
);

   localparam int CNT_W = $clog2(NUM_BITS);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BITS - 1);

   state_t state, state_next;

   logic [NUM_BITS-1:0] op_a_sr;
   logic [NUM_BITS-1:0] op_b_sr;
   // Holds only the upper NUM_BITS-1 partial result bits; the last cell bit joins at completion.
   logic [NUM_BITS-2:0] acc_sr;
   logic [NUM_BITS-1:0] acc_next;
   logic [CNT_W-1:0]    bit_cnt;
   logic                carry_reg;
   logic                cell_sum;
   logic                cell_cout;
   logic                load;
   logic                last_bit;

   adder_1bit u_cell (
      .a         (op_a_sr[0]),
      .b         (op_b_sr[0]),
      .carry_in  (carry_reg),
      .sum       (cell_sum),
      .carry_out (cell_cout)
   );

   assign load     = start && (state == IDLE || state == DONE);
   assign last_bit = (state == ADD) && (bit_cnt == LAST_CNT);
   assign acc_next = {cell_sum, acc_sr};

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) state <= IDLE;
      else        state <= state_next;
   end

   // NOTE: defaults come first so no path through this block can leave a latch behind.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = ADD;
         ADD:     if (bit_cnt == LAST_CNT) state_next = DONE;
         DONE:    state_next = start ? ADD : IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         busy      <= 1'b0;
         done      <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         op_a_sr   <= '0;
         op_b_sr   <= '0;
         acc_sr    <= '0;
         bit_cnt   <= '0;
         carry_reg <= 1'b0;
      end else begin
         busy <= (state_next == ADD);
         done <= (state_next == DONE);
         if (load) begin
            op_a_sr   <= a;
            op_b_sr   <= (op_sub == OP_SUB) ? ~b : b;
            carry_reg <= op_sub;
            bit_cnt   <= '0;
            acc_sr    <= '0;
         end else if (state == ADD) begin
            op_a_sr   <= op_a_sr >> 1;
            op_b_sr   <= op_b_sr >> 1;
            carry_reg <= cell_cout;
            acc_sr    <= acc_next[NUM_BITS-1:1];
            bit_cnt   <= bit_cnt + 1'b1;
            // carry_reg still holds the carry into the MSB on the final bit.
            if (last_bit) begin
               sum       <= acc_next;
               carry_out <= cell_cout;
               overflow  <= carry_reg ^ cell_cout;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Scoreboard bench for serial_add_ctrl: directed plan plus randomized add/subtract traffic.
module tb_serial_add_ctrl;

   localparam int N = 8;

   typedef struct packed {
      logic [N-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   logic         clk = 1'b0;
   logic         n_rst;
   logic         start;
   logic         op_sub;
   logic [N-1:0] a;
   logic [N-1:0] b;
   logic         busy;
   logic         done;
   logic [N-1:0] sum;
   logic         carry_out;
   logic         overflow;

   int   checks = 0;
   int   errors = 0;
   int   done_seen = 0;
   int   dones_expected = 0;
   exp_t exp_q[$];
   exp_t held = '0;

   serial_add_ctrl #(.NUM_BITS(N)) dut (
      .clk       (clk),
      .n_rst     (n_rst),
      .start     (start),
      .op_sub    (op_sub),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // Reference: plain integer arithmetic on the operands, flags from sign rules.
   function automatic exp_t model(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
      exp_t  r;
      int    ux, uy, total;
      bit    sx, sy, sr;
      ux = int'(x);
      uy = s ? ((1 << N) - int'(y)) : int'(y);
      total = ux + uy;
      r.sum = N'(total);
      if (s) r.cout = (int'(x) >= int'(y));
      else   r.cout = (total >= (1 << N));
      sx = x[N-1];
      sy = y[N-1];
      sr = r.sum[N-1];
      if (s) r.ovf = (sx != sy) && (sr != sx);
      else   r.ovf = (sx == sy) && (sr != sx);
      return r;
   endfunction

   // Monitor: pops on every done pulse, otherwise demands the held result is stable.
   always @(negedge clk) begin
      if (!n_rst) begin
         held = '0;
         check("rst_busy", busy, 0);
         check("rst_done", done, 0);
         check("rst_sum", sum, 0);
      end else if (done) begin
         done_seen++;
         if (exp_q.size() == 0) begin
            check("unexpected_done", done, 0);
         end else begin
            held = exp_q.pop_front();
            check("sum", sum, held.sum);
            check("carry_out", carry_out, held.cout);
            check("overflow", overflow, held.ovf);
            check("busy_with_done", busy, 0);
         end
      end else begin
         check("hold_sum", sum, held.sum);
         check("hold_flags", {carry_out, overflow}, {held.cout, held.ovf});
      end
   end

   // Presents an operation; returns just after the edge that samples it.
   task automatic start_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
      a = x;
      b = y;
      op_sub = s;
      start = 1'b1;
      exp_q.push_back(model(x, y, s));
      dones_expected++;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int cycles_expected);
      int cyc;
      cyc = 0;
      while (1) begin
         @(posedge clk);
         #1;
         cyc++;
         if (done) break;
         check("busy_during_op", busy, 1);
         if (cyc > 3 * N) begin
            check("done_timeout", done, 1);
            break;
         end
      end
      check("busy_cycles", cyc, cycles_expected);
   endtask

   task automatic run_op(input logic [N-1:0] x, input logic [N-1:0] y, input logic s);
      @(posedge clk);
      #1;
      start_op(x, y, s);
      wait_done(N);
   endtask

   initial begin
      n_rst = 1'b0;
      start = 1'b0;
      op_sub = 1'b0;
      a = '0;
      b = '0;
      #12;
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_sum", sum, 0);
      check("reset_flags", {carry_out, overflow}, 2'b00);
      #10;
      n_rst = 1'b1;

      // Basic add, signed overflow, unsigned wrap, subtracts.
      run_op(8'd100, 8'd27, 1'b0);
      run_op(8'h7F, 8'h01, 1'b0);
      run_op(8'hFF, 8'h01, 1'b0);
      run_op(8'd5, 8'd7, 1'b1);
      run_op(8'h80, 8'h01, 1'b1);

      // Start during ADD is ignored.
      @(posedge clk);
      #1;
      start_op(8'd3, 8'd4, 1'b0);
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      a = 8'hAA;
      b = 8'h55;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      wait_done(N - 3);

      // Asynchronous reset in the middle of an operation.
      @(posedge clk);
      #1;
      start_op(8'h0F, 8'h01, 1'b0);
      repeat (4) @(posedge clk);
      #2;
      n_rst = 1'b0;
      void'(exp_q.pop_back());
      dones_expected--;
      #1;
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      check("abort_sum", sum, 0);
      check("abort_flags", {carry_out, overflow}, 2'b00);
      repeat (2) @(posedge clk);
      #3;
      n_rst = 1'b1;
      repeat (12) @(posedge clk);
      #1;
      run_op(8'd1, 8'd1, 1'b0);

      // Back-to-back with start held high.
      @(posedge clk);
      #1;
      a = 8'd10;
      b = 8'd20;
      op_sub = 1'b0;
      start = 1'b1;
      exp_q.push_back(model(8'd10, 8'd20, 1'b0));
      dones_expected++;
      @(posedge clk);
      #1;
      wait_done(N);
      a = 8'd1;
      b = 8'd2;
      exp_q.push_back(model(8'd1, 8'd2, 1'b0));
      dones_expected++;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("b2b_busy_restart", busy, 1);
      wait_done(N);

      // Randomized traffic, mixing idle gaps with back-to-back starts.
      for (int i = 0; i < 40; i++) begin
         logic [N-1:0] x, y;
         logic         s;
         x = N'($urandom);
         y = N'($urandom);
         s = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 1) == 0) begin
            @(posedge clk);
            #1;
         end
         start_op(x, y, s);
         wait_done(N);
      end

      repeat (3) @(posedge clk);
      #1;
      check("queue_empty", exp_q.size(), 0);
      check("done_count", done_seen, dones_expected);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract engine built around a single 1-bit full-adder cell.
- Latches two NUM_BITS operands on a start request, then feeds the cell one bit per clock, LSB first, with a registered carry loop.
- Reports a held result with carry and signed-overflow flags, plus a one-cycle done pulse.
- Sits between a requesting controller and any consumer that can trade latency for area.

Parameters:
NUM_BITS, 8, operand/result width in bits (legal 2..32).

Ports:
clk  input  1  system clock, rising-edge
n_rst  input  1  asynchronous active-low reset
start  input  1  request; sampled only in IDLE or DONE
op_sub  input  1  0 = a+b, 1 = a-b; sampled with start
a  input  NUM_BITS  operand A; sampled with start
b  input  NUM_BITS  operand B; sampled with start
busy  output  1  high while bits are being processed
done  output  1  one-cycle pulse when the result registers update
sum  output  NUM_BITS  result, held until the next completion
carry_out  output  1  final carry; for subtract, 1 = no borrow
overflow  output  1  signed overflow: carry into MSB XOR carry out of MSB

Behaviour:
- Interface decision: one clock, clk; reset n_rst, asynchronous, active-low.
- Reset values (while n_rst=0): state IDLE; busy=0; done=0; sum=0; carry_out=0; overflow=0; all internal shift, carry and count registers 0.
- States:
  - IDLE: busy=0, done=0. start=1 -> ADD.
  - ADD: busy=1. Processes one bit per edge. bit_cnt==NUM_BITS-1 -> DONE.
  - DONE: done=1, busy=0, lasts one cycle. start=1 -> ADD (back-to-back accepted); else -> IDLE.
- Load (edge that samples start):
  - opA_sr <= a.
  - opB_sr <= op_sub ? ~b : b.
  - carry_reg <= op_sub.
  - bit_cnt <= 0.
  - acc_sr <= 0.
- Each ADD edge:
  - Cell inputs: a=opA_sr[0], b=opB_sr[0], carry_in=carry_reg.
  - carry_reg <= cell carry_out.
  - acc_sr shifts right with the cell sum entering at the MSB.
  - opA_sr and opB_sr shift right.
  - bit_cnt increments.
  - On the last bit (bit_cnt==NUM_BITS-1), msb_cin <= carry_reg (carry into MSB).
- Completion (edge ADD->DONE):
  - sum <= final shifted acc_sr value (including the last sum bit).
  - carry_out <= cell carry_out.
  - overflow <= carry_reg XOR cell carry_out.
- Latency: with start sampled at edge 0, busy is high after edges 1..NUM_BITS-1 (and after edge 0). done and the new result appear after edge NUM_BITS; busy drops at the same edge.
- Outputs are registered.
- sum, carry_out and overflow change only at completion or reset. Intermediate shifts are never visible on sum.
- start while in ADD: ignored, no queuing; operands are not re-sampled.
- start in DONE: accepted. done still pulses exactly once for the previous operation; busy returns to 1 on the next edge.
- Reset mid-operation: immediate abort to IDLE, all outputs cleared, no done pulse.
- Width rules: all arithmetic is modulo 2^NUM_BITS. bit_cnt width is clog2(NUM_BITS).
- Subtract uses two's complement (invert B, carry-in 1).
- If start and op_sub change in the same cycle as DONE, the new op_sub value is used for the new operation.

Decomposition:
- Package serial_add_pkg:
  - state_t enum {IDLE, ADD, DONE}.
  - Constants OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module: the team's existing 1-bit full-adder cell, adder_1bit, instantiated once as the bit datapath.
- FSM, shift registers, counter and carry flop all live in serial_add_ctrl.

Test Plan (NUM_BITS=8):
1. Basic add: a=100, b=27, op_sub=0, start pulsed -> busy high for 8 cycles; done pulses once at edge 8; sum=127, carry_out=0, overflow=0.
2. Signed overflow: a=0x7F, b=0x01 add -> sum=0x80, carry_out=0, overflow=1. Unsigned wrap: a=0xFF, b=0x01 add -> sum=0x00, carry_out=1, overflow=0.
3. Subtract: a=5, b=7, op_sub=1 -> sum=0xFE, carry_out=0 (borrow), overflow=0. a=0x80, b=0x01 sub -> sum=0x7F, carry_out=1, overflow=1.
4. Busy protection: start with a=3, b=4; at cycle 3 assert start with a=0xAA, b=0x55 -> ignored; result sum=7 at edge 8; one done pulse only.
5. Reset mid-op: start a=0x0F, b=0x01; drop n_rst asynchronously during bit 4 -> busy=0, sum=0, flags 0 immediately; no done after release; a subsequent start with a=1, b=1 gives sum=2 correctly.
6. Back-to-back: hold start high with a=10, b=20, then a=1, b=2 presented in the DONE cycle -> done pulses at edges 8 and 17, sum=30 then 3; sum holds 30 between the two pulses.
